// File: rtl/rv32i_pkg.sv
// Shared constants and encodings for the pipelined RV32I core.
// Covers the ALU operation codes, the result-source select and the forwarding select.
package rv32i_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_ctl_e;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/ex_fwd_unit.sv
// EX-stage forwarding selector: picks the newest producer for each ALU source register.
// A MEM producer is younger than a WB producer, so it wins; x0 is never forwarded.
module ex_fwd_unit
   import rv32i_pkg::*;
(
   input  logic [REG_AW-1:0] i_ex_rs1,
   input  logic [REG_AW-1:0] i_ex_rs2,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_reg_write,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_reg_write,
   output fwd_sel_e          o_fwd_a,
   output fwd_sel_e          o_fwd_b
);

   function automatic fwd_sel_e pick(input logic [REG_AW-1:0] rs);
      if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == rs))
         return FWD_MEM;
      else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == rs))
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

   always_comb begin
      o_fwd_a = pick(i_ex_rs1);
      o_fwd_b = pick(i_ex_rs2);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, ALU operand selection and load-use detection.
// Produces the ALU SrcA/SrcB/ALUControl combinationally from the stored stage state.
module id_ex_stage
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [3:0]        id_alu_control,
   input  logic              id_alu_src_a,
   input  logic              id_alu_src_b,
   input  logic              id_reg_write,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic              id_jump,
   input  logic [1:0]        id_result_src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              mem_reg_write,
   input  logic              wb_reg_write,
   input  logic [XLEN-1:0]   mem_alu_result,
   input  logic [XLEN-1:0]   wb_result,
   output logic              load_use_hazard,
   output logic [XLEN-1:0]   ex_src_a,
   output logic [XLEN-1:0]   ex_src_b,
   output logic [3:0]        ex_alu_control,
   output logic [XLEN-1:0]   ex_write_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic [1:0]        ex_result_src
);

   logic              r_valid, r_reg_write, r_mem_write, r_branch, r_jump;
   logic              r_alu_src_a, r_alu_src_b;
   logic [1:0]        r_result_src;
   logic [3:0]        r_alu_control;
   logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
   logic [XLEN-1:0]   r_rd1, r_rd2, r_imm, r_pc;

   fwd_sel_e          w_fwd_a, w_fwd_b;
   logic [XLEN-1:0]   w_fwd_rs1, w_fwd_rs2;
   logic              w_load_use;

   ex_fwd_unit u_fwd (
      .i_ex_rs1        (r_rs1),
      .i_ex_rs2        (r_rs2),
      .i_mem_rd        (mem_rd),
      .i_mem_reg_write (mem_reg_write),
      .i_wb_rd         (wb_rd),
      .i_wb_reg_write  (wb_reg_write),
      .o_fwd_a         (w_fwd_a),
      .o_fwd_b         (w_fwd_b)
   );

   always_comb begin
      unique case (w_fwd_a)
         FWD_MEM: w_fwd_rs1 = mem_alu_result;
         FWD_WB:  w_fwd_rs1 = wb_result;
         default: w_fwd_rs1 = r_rd1;
      endcase
      unique case (w_fwd_b)
         FWD_MEM: w_fwd_rs2 = mem_alu_result;
         FWD_WB:  w_fwd_rs2 = wb_result;
         default: w_fwd_rs2 = r_rd2;
      endcase
   end

   // A stalled pipeline does not advance, so no bubble may be inserted while stall is high.
   assign w_load_use = r_valid && (r_result_src == RES_LOAD) && (r_rd != '0) &&
                       ((r_rd == id_rs1) || (r_rd == id_rs2)) && id_valid && !stall;

   // During a stall the operand data keeps tracking forwarded values so a WB retirement is not lost.
   always_ff @(posedge clk) begin
      if (rst || flush || w_load_use) begin
         r_valid       <= 1'b0;
         r_reg_write   <= 1'b0;
         r_mem_write   <= 1'b0;
         r_branch      <= 1'b0;
         r_jump        <= 1'b0;
         r_alu_src_a   <= 1'b0;
         r_alu_src_b   <= 1'b0;
         r_result_src  <= '0;
         r_alu_control <= '0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_rd          <= '0;
         r_rd1         <= '0;
         r_rd2         <= '0;
         r_imm         <= '0;
         r_pc          <= '0;
      end else if (stall) begin
         r_rd1 <= w_fwd_rs1;
         r_rd2 <= w_fwd_rs2;
      end else begin
         r_valid       <= id_valid;
         r_reg_write   <= id_reg_write;
         r_mem_write   <= id_mem_write;
         r_branch      <= id_branch;
         r_jump        <= id_jump;
         r_alu_src_a   <= id_alu_src_a;
         r_alu_src_b   <= id_alu_src_b;
         r_result_src  <= id_result_src;
         r_alu_control <= id_alu_control;
         r_rs1         <= id_rs1;
         r_rs2         <= id_rs2;
         r_rd          <= id_rd;
         r_rd1         <= id_rd1;
         r_rd2         <= id_rd2;
         r_imm         <= id_imm;
         r_pc          <= id_pc;
      end
   end

   assign load_use_hazard = w_load_use;
   assign ex_src_a        = r_alu_src_a ? r_pc  : w_fwd_rs1;
   assign ex_src_b        = r_alu_src_b ? r_imm : w_fwd_rs2;
   assign ex_write_data   = w_fwd_rs2;
   assign ex_alu_control  = r_alu_control;
   assign ex_rd           = r_rd;
   assign ex_pc           = r_pc;
   assign ex_imm          = r_imm;
   assign ex_valid        = r_valid;
   assign ex_reg_write    = r_reg_write;
   assign ex_mem_write    = r_mem_write;
   assign ex_branch       = r_branch;
   assign ex_jump         = r_jump;
   assign ex_result_src   = r_result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, capture, forwarding, x0, load-use, stall/flush, immediates.
// Expected values are hand-computed constants in each test task.
module tb_id_ex_stage;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
   logic [31:0] id_rd1, id_rd2, id_imm, id_pc, mem_alu_result, wb_result;
   logic [3:0]  id_alu_control;
   logic        id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_write, id_branch, id_jump;
   logic [1:0]  id_result_src;
   logic        mem_reg_write, wb_reg_write;
   logic        load_use_hazard;
   logic [31:0] ex_src_a, ex_src_b, ex_write_data, ex_pc, ex_imm;
   logic [3:0]  ex_alu_control;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_reg_write, ex_mem_write, ex_branch, ex_jump;
   logic [1:0]  ex_result_src;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_pc(id_pc), .id_alu_control(id_alu_control),
      .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
      .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_branch(id_branch),
      .id_jump(id_jump), .id_result_src(id_result_src),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_alu_result(mem_alu_result), .wb_result(wb_result),
      .load_use_hazard(load_use_hazard), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
      .ex_alu_control(ex_alu_control), .ex_write_data(ex_write_data), .ex_rd(ex_rd),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_result_src(ex_result_src)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] ctl,
                         input logic srca, input logic srcb, input logic regw,
                         input logic memw, input logic [1:0] rsrc);
      id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_pc = pc;
      id_alu_control = ctl; id_alu_src_a = srca; id_alu_src_b = srcb;
      id_reg_write = regw; id_mem_write = memw; id_branch = 1'b0; id_jump = 1'b0;
      id_result_src = rsrc;
   endtask

   task automatic clear_fwd();
      mem_rd = '0; wb_rd = '0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      mem_alu_result = '0; wb_result = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      clear_fwd();
      set_id(5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom,
             4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 2'($urandom));
      id_branch = 1'b1; id_jump = 1'b1;
      step(); step();
      vectors++;
      if ({ex_valid, ex_reg_write, ex_mem_write, ex_branch, ex_jump} !== 5'b0) begin
         miscompares++; $display("[TB] FAIL reset_ctl: got %b expected 00000",
            {ex_valid, ex_reg_write, ex_mem_write, ex_branch, ex_jump});
      end
      vectors++;
      if ({ex_src_a, ex_src_b, ex_write_data} !== 96'h0) begin
         miscompares++; $display("[TB] FAIL reset_data: a=%h b=%h wd=%h expected 0", ex_src_a, ex_src_b, ex_write_data);
      end
      vectors++;
      if ({ex_alu_control, ex_rd, ex_result_src, ex_pc, ex_imm} !== 75'h0) begin
         miscompares++; $display("[TB] FAIL reset_fields: ctl=%h rd=%h rs=%h pc=%h imm=%h expected 0",
            ex_alu_control, ex_rd, ex_result_src, ex_pc, ex_imm);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h40, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, RES_ALU);
      step();
      vectors++;
      if (ex_src_a !== 32'd5) begin miscompares++; $display("[TB] FAIL add_src_a: got %h expected 5", ex_src_a); end
      vectors++;
      if (ex_src_b !== 32'd7) begin miscompares++; $display("[TB] FAIL add_src_b: got %h expected 7", ex_src_b); end
      vectors++;
      if ({ex_valid, ex_reg_write, ex_rd} !== {1'b1, 1'b1, 5'd3}) begin
         miscompares++; $display("[TB] FAIL add_ctl: got v=%b rw=%b rd=%0d expected 1 1 3", ex_valid, ex_reg_write, ex_rd);
      end
   endtask

   task automatic test_forward_priority();
      set_id(5'd5, 5'd5, 5'd9, 32'hAAAA, 32'hBBBB, 32'h44, 32'h80, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, RES_ALU);
      step();
      mem_rd = 5'd5; mem_reg_write = 1'b1; mem_alu_result = 32'h10;
      wb_rd = 5'd5; wb_reg_write = 1'b1; wb_result = 32'h20;
      #1;
      vectors++;
      if (ex_src_a !== 32'h10) begin miscompares++; $display("[TB] FAIL fwd_mem_wins: got %h expected 10", ex_src_a); end
      vectors++;
      if (ex_src_b !== 32'h44) begin miscompares++; $display("[TB] FAIL fwd_imm_b: got %h expected 44", ex_src_b); end
      vectors++;
      if (ex_write_data !== 32'h10) begin miscompares++; $display("[TB] FAIL fwd_store_data: got %h expected 10", ex_write_data); end
      mem_reg_write = 1'b0;
      #1;
      vectors++;
      if (ex_src_a !== 32'h20) begin miscompares++; $display("[TB] FAIL fwd_wb_only: got %h expected 20", ex_src_a); end
      wb_reg_write = 1'b0;
      #1;
      vectors++;
      if (ex_src_a !== 32'hAAAA) begin miscompares++; $display("[TB] FAIL fwd_none: got %h expected aaaa", ex_src_a); end
      clear_fwd();
   endtask

   task automatic test_x0();
      set_id(5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 32'hC0, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, RES_ALU);
      step();
      mem_rd = 5'd0; mem_reg_write = 1'b1; mem_alu_result = 32'hDEAD;
      wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 32'hBEEF;
      #1;
      vectors++;
      if (ex_src_a !== 32'h0) begin miscompares++; $display("[TB] FAIL x0_no_fwd: got %h expected 0", ex_src_a); end
      clear_fwd();
   endtask

   task automatic test_load_use();
      set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h0, 32'h200, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, RES_LOAD);
      step();
      set_id(5'd4, 5'd4, 5'd6, 32'h999, 32'h999, 32'h0, 32'h204, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, RES_ALU);
      stall = 1'b1;
      #1;
      vectors++;
      if (load_use_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_masked_by_stall: got %b expected 0", load_use_hazard); end
      stall = 1'b0;
      #1;
      vectors++;
      if (load_use_hazard !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_detect: got %b expected 1", load_use_hazard); end
      step();
      mem_rd = 5'd4; mem_reg_write = 1'b1; mem_alu_result = 32'h100;
      #1;
      vectors++;
      if ({ex_valid, ex_reg_write, ex_rd} !== 7'b0) begin
         miscompares++; $display("[TB] FAIL lu_bubble: got v=%b rw=%b rd=%0d expected 0 0 0", ex_valid, ex_reg_write, ex_rd);
      end
      vectors++;
      if (load_use_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_one_cycle: got %b expected 0", load_use_hazard); end
      step();
      clear_fwd();
      wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h77;
      #1;
      vectors++;
      if ({ex_src_a, ex_src_b} !== {32'h77, 32'h77}) begin
         miscompares++; $display("[TB] FAIL lu_wb_fwd: got a=%h b=%h expected 77 77", ex_src_a, ex_src_b);
      end
      vectors++;
      if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin
         miscompares++; $display("[TB] FAIL lu_after: got v=%b rd=%0d expected 1 6", ex_valid, ex_rd);
      end
      clear_fwd();
   endtask

   task automatic test_stall();
      set_id(5'd1, 5'd7, 5'd8, 32'd3, 32'd0, 32'h0, 32'h300, ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, RES_ALU);
      step();
      stall = 1'b1;
      set_id(5'd2, 5'd3, 5'd9, 32'hBAD, 32'hBAD, 32'h0, 32'h304, ALU_OR, 1'b0, 1'b0, 1'b1, 1'b0, RES_ALU);
      wb_rd = 5'd7; wb_reg_write = 1'b1; wb_result = 32'h55;
      step();
      wb_reg_write = 1'b0; wb_result = 32'h0;
      step(); step();
      stall = 1'b0; id_valid = 1'b0;
      #1;
      vectors++;
      if (ex_src_b !== 32'h55) begin miscompares++; $display("[TB] FAIL stall_keep_wb: got %h expected 55", ex_src_b); end
      vectors++;
      if ({ex_rd, ex_src_a, ex_alu_control} !== {5'd8, 32'd3, 4'(ALU_SUB)}) begin
         miscompares++; $display("[TB] FAIL stall_hold: got rd=%0d a=%h ctl=%h expected 8 3 1", ex_rd, ex_src_a, ex_alu_control);
      end
      set_id(5'd1, 5'd2, 5'd10, 32'h1, 32'h2, 32'h0, 32'h400, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1, RES_ALU);
      step();
      stall = 1'b1;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0; stall = 1'b0;
      vectors++;
      if ({ex_valid, ex_reg_write, ex_mem_write, ex_rd, ex_src_a} !== 40'h0) begin
         miscompares++; $display("[TB] FAIL flush_in_stall: got v=%b rw=%b mw=%b rd=%0d a=%h expected all 0",
            ex_valid, ex_reg_write, ex_mem_write, ex_rd, ex_src_a);
      end
   endtask

   task automatic test_imm();
      set_id(5'd1, 5'd2, 5'd12, 32'h11, 32'h22, 32'h800, 32'h100, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, RES_ALU);
      step();
      vectors++;
      if ({ex_src_a, ex_src_b} !== {32'h100, 32'h800}) begin
         miscompares++; $display("[TB] FAIL auipc_ops: got a=%h b=%h expected 100 800", ex_src_a, ex_src_b);
      end
      vectors++;
      if (ex_write_data !== 32'h22) begin miscompares++; $display("[TB] FAIL imm_store_data: got %h expected 22", ex_write_data); end
      set_id(5'd3, 5'd0, 5'd13, 32'hF0, 32'h0, 32'h4, 32'h104, ALU_SRA, 1'b0, 1'b1, 1'b1, 1'b0, RES_PC4);
      id_jump = 1'b1;
      step();
      vectors++;
      if ({ex_alu_control, ex_result_src, ex_jump} !== {4'(ALU_SRA), 2'(RES_PC4), 1'b1}) begin
         miscompares++; $display("[TB] FAIL ctl_pass: got ctl=%h rs=%b j=%b expected 7 10 1", ex_alu_control, ex_result_src, ex_jump);
      end
      vectors++;
      if ({ex_src_a, ex_src_b, ex_pc, ex_imm} !== {32'hF0, 32'h4, 32'h104, 32'h4}) begin
         miscompares++; $display("[TB] FAIL addi_ops: got a=%h b=%h pc=%h imm=%h expected f0 4 104 4", ex_src_a, ex_src_b, ex_pc, ex_imm);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_forward_priority();
      test_x0();
      test_load_use();
      test_stall();
      test_imm();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
